audio_sram_ctrl: RTL and testbench

AUDIO_SRAM_CTRL -- requirements
Module: audio_sram_ctrl

---
 rtl/audio_sram_ctrl.sv | 172 +++++++++++++++++
 tb/tb_audio_sram_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_sram_ctrl.sv
// Stereo record/playback controller over a 16-bit async SRAM.
// Ports: i_clk/i_rst, start/stop pulses, record sink, play source, SRAM, o_length, o_state.
module audio_sram_ctrl #(
  parameter int ADDR_W = 20
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start_rec,
  input  logic              i_start_play,
  input  logic              i_stop,
  output logic              record_audio_ready,
  input  logic [31:0]       record_audio_data,
  input  logic              record_audio_valid,
  output logic              play_audio_valid,
  output logic [31:0]       play_audio_data,
  input  logic              play_audio_ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_wdata,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  input  logic [15:0]       sram_rdata,
  output logic [ADDR_W-1:0] o_length,
  output logic [2:0]        o_state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    REC_WAIT   = 3'd1,
    REC_WR_HI  = 3'd2,
    REC_WR_LO  = 3'd3,
    PLAY_RD_HI = 3'd4,
    PLAY_RD_LO = 3'd5,
    PLAY_OUT   = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] MAX =
    {1'b1, {(ADDR_W-1){1'b0}}};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] pptr_q, pptr_d;
  logic [31:0]       rec_q, rec_d;
  logic [31:0]       rd_q, rd_d;
  logic              stop_q, stop_d;

  logic [ADDR_W-1:0] len_inc;
  logic [ADDR_W-1:0] pptr_inc;
  logic [ADDR_W-1:0] rec_base;
  logic [ADDR_W-1:0] play_base;

  // len_q doubles as the record pointer: the next sample lands at index len_q.
  assign len_inc   = len_q + ADDR_W'(1);
  assign pptr_inc  = pptr_q + ADDR_W'(1);
  assign rec_base  = {len_q[ADDR_W-2:0], 1'b0};
  assign play_base = {pptr_q[ADDR_W-2:0], 1'b0};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      pptr_q  <= '0;
      rec_q   <= '0;
      rd_q    <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      pptr_q  <= pptr_d;
      rec_q   <= rec_d;
      rd_q    <= rd_d;
      stop_q  <= stop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    pptr_d  = pptr_q;
    rec_d   = rec_q;
    rd_d    = rd_q;
    stop_d  = stop_q;
    unique case (state_q)
      IDLE: begin
        if (i_start_rec) begin
          len_d   = '0;
          stop_d  = 1'b0;
          state_d = REC_WAIT;
        end else if (i_start_play && len_q != '0) begin
          pptr_d  = '0;
          state_d = PLAY_RD_HI;
        end
      end
      REC_WAIT: begin
        if (i_stop) begin
          state_d = IDLE;
        end else if (record_audio_valid) begin
          rec_d   = record_audio_data;
          state_d = REC_WR_HI;
        end
      end
      REC_WR_HI: begin
        // A stop here must not tear the sample; defer it past the right word.
        if (i_stop) stop_d = 1'b1;
        state_d = REC_WR_LO;
      end
      REC_WR_LO: begin
        len_d  = len_inc;
        stop_d = 1'b0;
        if (len_inc == MAX || stop_q || i_stop)
          state_d = IDLE;
        else
          state_d = REC_WAIT;
      end
      PLAY_RD_HI: begin
        rd_d[31:16] = sram_rdata;
        state_d = i_stop ? IDLE : PLAY_RD_LO;
      end
      PLAY_RD_LO: begin
        rd_d[15:0] = sram_rdata;
        state_d = i_stop ? IDLE : PLAY_OUT;
      end
      PLAY_OUT: begin
        if (i_stop) begin
          state_d = IDLE;
        end else if (play_audio_ready) begin
          pptr_d  = pptr_inc;
          state_d = (pptr_inc == len_q) ? IDLE : PLAY_RD_HI;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore decode: every SRAM strobe follows state alone, so reset
  // kills an in-flight cycle the moment state_q returns to IDLE.
  always_comb begin
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_addr  = '0;
    sram_wdata = '0;
    unique case (state_q)
      REC_WR_HI: begin
        sram_we_n  = 1'b0;
        sram_addr  = rec_base;
        sram_wdata = rec_q[31:16];
      end
      REC_WR_LO: begin
        sram_we_n  = 1'b0;
        sram_addr  = rec_base | ADDR_W'(1);
        sram_wdata = rec_q[15:0];
      end
      PLAY_RD_HI: begin
        sram_oe_n = 1'b0;
        sram_addr = play_base;
      end
      PLAY_RD_LO: begin
        sram_oe_n = 1'b0;
        sram_addr = play_base | ADDR_W'(1);
      end
      default: begin
        sram_we_n = 1'b1;
      end
    endcase
  end

  assign record_audio_ready = (state_q == REC_WAIT);
  assign play_audio_valid   = (state_q == PLAY_OUT);
  assign play_audio_data    = rd_q;
  assign o_length           = len_q;
  assign o_state            = state_q;

endmodule

// File: tb/tb_audio_sram_ctrl.sv
// Self-checking bench for audio_sram_ctrl with a small SRAM model.
// Vector table, directed corner sequences, and randomized record/play rounds.
module tb_audio_sram_ctrl;

  localparam int AW   = 4;
  localparam int MAXS = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_rec = 1'b0;
  logic          start_play = 1'b0;
  logic          stop = 1'b0;
  logic          rec_ready;
  logic [31:0]   rec_data = '0;
  logic          rec_valid = 1'b0;
  logic          play_valid;
  logic [31:0]   play_data;
  logic          play_ready = 1'b0;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_wdata;
  logic          sram_we_n;
  logic          sram_oe_n;
  logic [15:0]   sram_rdata;
  logic [AW-1:0] length;
  logic [2:0]    state;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int bus_err = 0;

  logic [15:0] mem [16] = '{default: 16'h0};

  always #5 clk = ~clk;

  audio_sram_ctrl #(.ADDR_W(AW)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_start_rec        (start_rec),
    .i_start_play       (start_play),
    .i_stop             (stop),
    .record_audio_ready (rec_ready),
    .record_audio_data  (rec_data),
    .record_audio_valid (rec_valid),
    .play_audio_valid   (play_valid),
    .play_audio_data    (play_data),
    .play_audio_ready   (play_ready),
    .sram_addr          (sram_addr),
    .sram_wdata         (sram_wdata),
    .sram_we_n          (sram_we_n),
    .sram_oe_n          (sram_oe_n),
    .sram_rdata         (sram_rdata),
    .o_length           (length),
    .o_state            (state)
  );

  // Async SRAM: reads return garbage unless output-enabled.
  assign sram_rdata = sram_oe_n ? 16'hA5A5 : mem[sram_addr];

  always @(negedge clk) begin
    if (!sram_we_n) begin
      mem[sram_addr] = sram_wdata;
      wr_count++;
    end
    if (!sram_we_n && !sram_oe_n) bus_err++;
    if (sram_we_n && sram_oe_n &&
        (sram_addr != '0 || sram_wdata != '0))
      bus_err++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        sr;
    logic        sp;
    logic        st;
    logic        rv;
    logic [31:0] rd;
    logic        pr;
    logic [2:0]  s;
    logic        rdy;
    logic        pv;
    logic [31:0] pd;
    logic        we;
    logic        oe;
    logic [3:0]  a;
    logic [15:0] wd;
    logic [3:0]  ln;
  } vec_t;

  vec_t tv [17];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rec;
    start_rec = 1'b1;
    tick();
    start_rec = 1'b0;
  endtask

  task automatic pulse_play;
    start_play = 1'b1;
    tick();
    start_play = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, output bit ok);
    int n = 0;
    rec_data  = d;
    rec_valid = 1'b1;
    while (!rec_ready && n < 50) begin
      tick();
      n++;
    end
    ok = rec_ready;
    if (ok) tick();
    rec_valid = 1'b0;
  endtask

  task automatic recv(input int dly,
                      output logic [31:0] d,
                      output bit ok);
    int n = 0;
    while (!play_valid && n < 50) begin
      tick();
      n++;
    end
    ok = play_valid;
    d  = '0;
    if (ok) begin
      repeat (dly) tick();
      d = play_data;
      play_ready = 1'b1;
      tick();
      play_ready = 1'b0;
    end
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (state != 3'd0 && n < 50) begin
      tick();
      n++;
    end
    ok = (state == 3'd0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " state"}, 32'(state), 32'd0);
    chk({tag, " rdy"}, 32'(rec_ready), 32'd0);
    chk({tag, " pv"}, 32'(play_valid), 32'd0);
    chk({tag, " we_n"}, 32'(sram_we_n), 32'd1);
    chk({tag, " oe_n"}, 32'(sram_oe_n), 32'd1);
    chk({tag, " addr"}, 32'(sram_addr), 32'd0);
    chk({tag, " wdata"}, 32'(sram_wdata), 32'd0);
    chk({tag, " len"}, 32'(length), 32'd0);
  endtask

  logic [31:0] q[$];
  logic [31:0] d;
  bit          ok;
  int          wc;
  int          hits;
  int          mism;
  int          n;

  initial begin
    tv[0]  = '{1,1,0,0,32'h0,0, 1,1,0,32'h0,1,1,0,16'h0,0};
    tv[1]  = '{0,0,0,1,32'h1234ABCD,0,
               2,0,0,32'h0,0,1,0,16'h1234,0};
    tv[2]  = '{0,0,0,0,32'h0,0, 3,0,0,32'h0,0,1,1,16'hABCD,0};
    tv[3]  = '{0,0,0,0,32'h0,0, 1,1,0,32'h0,1,1,0,16'h0,1};
    tv[4]  = '{0,0,0,1,32'h0001FFFF,0,
               2,0,0,32'h0,0,1,2,16'h0001,1};
    tv[5]  = '{0,0,0,0,32'h0,0, 3,0,0,32'h0,0,1,3,16'hFFFF,1};
    tv[6]  = '{0,0,0,0,32'h0,0, 1,1,0,32'h0,1,1,0,16'h0,2};
    tv[7]  = '{0,0,1,0,32'h0,0, 0,0,0,32'h0,1,1,0,16'h0,2};
    tv[8]  = '{0,0,1,0,32'h0,0, 0,0,0,32'h0,1,1,0,16'h0,2};
    tv[9]  = '{0,1,0,0,32'h0,0, 4,0,0,32'h0,1,0,0,16'h0,2};
    tv[10] = '{0,0,0,0,32'h0,0, 5,0,0,32'h0,1,0,1,16'h0,2};
    tv[11] = '{0,0,0,0,32'h0,0,
               6,0,1,32'h1234ABCD,1,1,0,16'h0,2};
    tv[12] = '{1,1,0,0,32'h0,0,
               6,0,1,32'h1234ABCD,1,1,0,16'h0,2};
    tv[13] = '{0,0,0,0,32'h0,1, 4,0,0,32'h0,1,0,2,16'h0,2};
    tv[14] = '{0,0,0,0,32'h0,0, 5,0,0,32'h0,1,0,3,16'h0,2};
    tv[15] = '{0,0,0,0,32'h0,0,
               6,0,1,32'h0001FFFF,1,1,0,16'h0,2};
    tv[16] = '{0,0,1,0,32'h0,0, 0,0,0,32'h0,1,1,0,16'h0,2};

    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("rst");
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      start_rec  = tv[i].sr;
      start_play = tv[i].sp;
      stop       = tv[i].st;
      rec_valid  = tv[i].rv;
      rec_data   = tv[i].rd;
      play_ready = tv[i].pr;
      tick();
      chk($sformatf("v%0d state", i), 32'(state), 32'(tv[i].s));
      chk($sformatf("v%0d rdy", i), 32'(rec_ready), 32'(tv[i].rdy));
      chk($sformatf("v%0d pv", i), 32'(play_valid), 32'(tv[i].pv));
      if (tv[i].pv)
        chk($sformatf("v%0d pdata", i), play_data, tv[i].pd);
      chk($sformatf("v%0d we_n", i), 32'(sram_we_n), 32'(tv[i].we));
      chk($sformatf("v%0d oe_n", i), 32'(sram_oe_n), 32'(tv[i].oe));
      chk($sformatf("v%0d addr", i), 32'(sram_addr), 32'(tv[i].a));
      chk($sformatf("v%0d wdata", i), 32'(sram_wdata), 32'(tv[i].wd));
      chk($sformatf("v%0d len", i), 32'(length), 32'(tv[i].ln));
    end
    start_rec = 0; start_play = 0; stop = 0;
    rec_valid = 0; play_ready = 0;
    chk("mem0", 32'(mem[0]), 32'h1234);
    chk("mem1", 32'(mem[1]), 32'hABCD);
    chk("mem2", 32'(mem[2]), 32'h0001);
    chk("mem3", 32'(mem[3]), 32'hFFFF);

    // Playback with a slow sink.
    pulse_play();
    recv(5, d, ok);
    chk("p39 ok0", 32'(ok), 32'd1);
    chk("p39 s0", d, 32'h1234ABCD);
    recv(5, d, ok);
    chk("p39 ok1", 32'(ok), 32'd1);
    chk("p39 s1", d, 32'h0001FFFF);
    chk("p39 idle", 32'(state), 32'd0);
    chk("p39 len", 32'(length), 32'd2);

    // Async reset mid-play, off the clock edge.
    pulse_play();
    tick();
    tick();
    chk("r43 inplay", 32'(play_valid), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk_reset_outs("r43");
    chk("r43 pdata", play_data, 32'h0);
    #2 rst = 1'b0;
    pulse_play();
    chk("empty play", 32'(state), 32'd0);

    // Stop during the left-word write still commits the sample.
    pulse_rec();
    rec_data  = 32'hCAFE0BAD;
    rec_valid = 1'b1;
    tick();
    rec_valid = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("s41 lo", 32'(state), 32'd3);
    tick();
    chk("s41 idle", 32'(state), 32'd0);
    chk("s41 len", 32'(length), 32'd1);
    chk("s41 m0", 32'(mem[0]), 32'hCAFE);
    chk("s41 m1", 32'(mem[1]), 32'h0BAD);

    // Reset during a write: no SRAM cycle afterwards.
    pulse_rec();
    rec_data  = 32'h11112222;
    rec_valid = 1'b1;
    tick();
    rec_valid = 1'b0;
    #1 rst = 1'b1;
    wc = wr_count;
    #2 rst = 1'b0;
    repeat (10) tick();
    chk("r37 writes", 32'(wr_count - wc), 32'd0);
    chk("r37 state", 32'(state), 32'd0);
    chk("r37 len", 32'(length), 32'd0);

    // Fill to capacity, then offer one more.
    pulse_rec();
    wc = wr_count;
    for (int k = 0; k < MAXS; k++) begin
      send(32'hF000_0000 | 32'(k * 257), ok);
      chk($sformatf("f40 acc%0d", k), 32'(ok), 32'd1);
    end
    rec_data  = 32'hDEADBEEF;
    rec_valid = 1'b1;
    hits = 0;
    repeat (20) begin
      tick();
      if (rec_ready) hits++;
    end
    rec_valid = 1'b0;
    chk("f40 rdy", 32'(hits), 32'd0);
    chk("f40 state", 32'(state), 32'd0);
    chk("f40 len", 32'(length), 32'd8);
    chk("f40 writes", 32'(wr_count - wc), 32'd16);
    mism = 0;
    for (int k = 0; k < MAXS; k++) begin
      d = 32'hF000_0000 | 32'(k * 257);
      if (mem[2*k] !== d[31:16]) mism++;
      if (mem[2*k+1] !== d[15:0]) mism++;
    end
    chk("f40 mem", 32'(mism), 32'd0);

    // Random record/stop/playback rounds against a sample queue.
    for (int r = 0; r < 12; r++) begin
      q.delete();
      n = $urandom_range(1, MAXS);
      pulse_rec();
      for (int k = 0; k < n; k++) begin
        repeat ($urandom_range(0, 3)) tick();
        d = $urandom;
        q.push_back(d);
        send(d, ok);
        chk($sformatf("r%0d acc", r), 32'(ok), 32'd1);
      end
      repeat ($urandom_range(0, 3)) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_idle(ok);
      chk($sformatf("r%0d idle", r), 32'(ok), 32'd1);
      chk($sformatf("r%0d len", r), 32'(length), 32'(n));
      mism = 0;
      for (int k = 0; k < n; k++) begin
        if (mem[2*k] !== q[k][31:16]) mism++;
        if (mem[2*k+1] !== q[k][15:0]) mism++;
      end
      chk($sformatf("r%0d mem", r), 32'(mism), 32'd0);
      pulse_play();
      for (int k = 0; k < n; k++) begin
        recv($urandom_range(0, 4), d, ok);
        chk($sformatf("r%0d rx%0d ok", r, k), 32'(ok), 32'd1);
        chk($sformatf("r%0d rx%0d", r, k), d, q[k]);
      end
      chk($sformatf("r%0d end", r), 32'(state), 32'd0);
      chk($sformatf("r%0d len2", r), 32'(length), 32'(n));
    end

    chk("sram bus", 32'(bus_err), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
